// File: rtl/fp_mul_pipe_hs.sv
// Pipelined IEEE-754 multiplier with valid/ready backpressure, tag side-channel,
// round-to-nearest-even, DAZ/FTZ handling and per-result status flags.
module fp_mul_pipe_hs #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  parameter  int TAG_W = 4,
  localparam int FW    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FW-1:0]    a_operand,
  input  logic [FW-1:0]    b_operand,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FW-1:0]    result,
  output logic [TAG_W-1:0] out_tag,
  output logic             invalid,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);

  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Classify / unpack
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  kind_t                  kind0;
  logic signed [EW-1:0]   esum0;

  always_comb begin
    ea     = a_operand[FW-2 -: EXP_W];
    eb     = b_operand[FW-2 -: EXP_W];
    fa     = a_operand[MAN_W-1:0];
    fb     = b_operand[MAN_W-1:0];
    a_nan  = (&ea) && (|fa);
    a_inf  = (&ea) && !(|fa);
    a_zero = !(|ea);
    b_nan  = (&eb) && (|fb);
    b_inf  = (&eb) && !(|fb);
    b_zero = !(|eb);
    kind0  = K_NUM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      kind0 = K_NAN;
    else if (a_inf || b_inf)
      kind0 = K_INF;
    else if (a_zero || b_zero)
      kind0 = K_ZERO;
    esum0 = $signed(EW'(ea)) + $signed(EW'(eb)) - E_BIAS;
  end

  logic                 s1_valid, s1_sign;
  logic [TAG_W-1:0]     s1_tag;
  kind_t                s1_kind;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic signed [EW-1:0] s1_exp;

  logic                 s2_valid, s2_sign;
  logic [TAG_W-1:0]     s2_tag;
  kind_t                s2_kind;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_exp;

  logic                 s3_valid, s3_sign, s3_g, s3_st;
  logic [TAG_W-1:0]     s3_tag;
  kind_t                s3_kind;
  logic [MAN_W-1:0]     s3_frac;
  logic signed [EW-1:0] s3_exp;

  // Normalise: put the leading one at the top of pn, split keep/guard/sticky
  logic [PW-2:0]        pn;
  logic signed [EW-1:0] e_n;
  logic [MAN_W-1:0]     frac_t;
  logic                 g_t, st_t;

  always_comb begin
    pn     = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    e_n    = s2_prod[PW-1] ? s2_exp + E_ONE : s2_exp;
    frac_t = pn[PW-2 -: MAN_W];
    g_t    = pn[MAN_W];
    st_t   = |pn[MAN_W-1:0];
  end

  // Round-to-nearest-even and pack
  logic                 rup, carry;
  logic [MAN_W-1:0]     frac_r;
  logic signed [EW-1:0] e_r;
  logic                 too_big, too_small;
  logic [FW-1:0]        res_n;
  logic                 inv_n, ovf_n, unf_n, inx_n;

  always_comb begin
    rup             = s3_g && (s3_st || s3_frac[0]);
    {carry, frac_r} = {1'b0, s3_frac} + (MAN_W+1)'(rup);
    e_r             = carry ? s3_exp + E_ONE : s3_exp;
    too_big         = (e_r >= E_MAX);
    too_small       = e_r[EW-1] || (e_r == '0);
    res_n = '0;
    inv_n = 1'b0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    inx_n = 1'b0;
    case (s3_kind)
      K_NAN: begin
        res_n = QNAN;
        inv_n = 1'b1;
      end
      K_INF:  res_n = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: res_n = {s3_sign, {(FW-1){1'b0}}};
      default: begin
        if (too_big) begin
          res_n = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_n = 1'b1;
          inx_n = 1'b1;
        end else if (too_small) begin
          res_n = {s3_sign, {(FW-1){1'b0}}};
          unf_n = 1'b1;
          inx_n = 1'b1;
        end else begin
          res_n = {s3_sign, e_r[EXP_W-1:0], frac_r};
          inx_n = s3_g || s3_st;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_tag    <= '0;
      s1_kind   <= K_ZERO;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_exp    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_tag    <= '0;
      s2_kind   <= K_ZERO;
      s2_prod   <= '0;
      s2_exp    <= '0;
      s3_valid  <= 1'b0;
      s3_sign   <= 1'b0;
      s3_g      <= 1'b0;
      s3_st     <= 1'b0;
      s3_tag    <= '0;
      s3_kind   <= K_ZERO;
      s3_frac   <= '0;
      s3_exp    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign   <= a_operand[FW-1] ^ b_operand[FW-1];
      s1_tag    <= in_tag;
      s1_kind   <= kind0;
      s1_ma     <= {1'b1, fa};
      s1_mb     <= {1'b1, fb};
      s1_exp    <= esum0;

      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_tag    <= s1_tag;
      s2_kind   <= s1_kind;
      s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
      s2_exp    <= s1_exp;

      s3_valid  <= s2_valid;
      s3_sign   <= s2_sign;
      s3_tag    <= s2_tag;
      s3_kind   <= s2_kind;
      s3_frac   <= frac_t;
      s3_g      <= g_t;
      s3_st     <= st_t;
      s3_exp    <= e_n;

      out_valid <= s3_valid;
      result    <= res_n;
      out_tag   <= s3_tag;
      invalid   <= inv_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
      inexact   <= inx_n;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe_hs.sv
// Bench for fp_mul_pipe_hs (binary32): directed vectors, random streams under
// backpressure against an arithmetic reference, latency and async-reset checks.
module tb_fp_mul_pipe_hs;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        invalid, overflow, underflow, inexact;

  int total = 0;
  int bad   = 0;

  fp_mul_pipe_hs #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .invalid(invalid), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
  } exp_t;

  logic [31:0] va[$];
  logic [31:0] vb[$];
  logic [31:0] vr[$];
  logic [3:0]  vf[$];

  function automatic logic [3:0] flags();
    return {invalid, overflow, underflow, inexact};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, rounded by quotient/remainder against half an ulp
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    logic s;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    bit an, ai, az, bn, bi, bz, inx;
    longint unsigned ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    an = (ea == 255) && (fa != 0);
    ai = (ea == 255) && (fa == 0);
    az = (ea == 0);
    bn = (eb == 255) && (fb != 0);
    bi = (eb == 255) && (fb == 0);
    bz = (eb == 0);
    f  = 4'b0000;
    if (an || bn || (ai && bz) || (bi && az)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (ai || bi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (az || bz) begin
      r = {s, 31'h0};
    end else begin
      ma = 64'h800000 + 64'(fa);
      mb = 64'h800000 + 64'(fb);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      inx = (rem != 0);
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], q[22:0]};
        f = {3'b000, inx};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    int c;
    x = $urandom;
    c = $urandom_range(0, 11);
    case (c)
      0: x[30:23] = 8'h00;
      1: begin x[30:23] = 8'hFF; x[22:0] = '0; end
      2: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
      3: x[30:23] = 8'($urandom_range(190, 254));
      4: x[30:23] = 8'($urandom_range(1, 64));
      5: begin x[22:12] = '0; x[30:23] = 8'($urandom_range(100, 150)); end
      default: if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) x[30:23] = 8'd127;
    endcase
    return x;
  endfunction

  task automatic add_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f);
    va.push_back(a);
    vb.push_back(b);
    vr.push_back(r);
    vf.push_back(f);
  endtask

  task automatic add_rand(input int n);
    logic [31:0] a, b, r;
    logic [3:0]  f;
    for (int i = 0; i < n; i++) begin
      a = rand_op();
      b = rand_op();
      model(a, b, r, f);
      add_op(a, b, r, f);
    end
  endtask

  // Streams the queued ops; every cycle with out_valid the output must equal the scoreboard head
  task automatic run_stream(input string nm, input bit rnd);
    exp_t sb[$];
    exp_t e;
    int n, sent, got, cyc;
    bit stalled_prev;
    n = va.size();
    sent = 0;
    got = 0;
    cyc = 0;
    stalled_prev = 0;
    while (got < n && cyc < n * 20 + 50) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
      if (sent < n) begin
        a_operand = va[sent];
        b_operand = vb[sent];
        in_tag    = 4'(sent);
      end
      #1;
      if (stalled_prev) chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_in_ready"}, 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk({nm, "_spurious"}, 64'(out_valid), 64'd0);
        end else begin
          e = sb[0];
          chk({nm, "_result"}, 64'(result), 64'(e.r));
          chk({nm, "_tag"}, 64'(out_tag), 64'(e.t));
          chk({nm, "_flags"}, 64'(flags()), 64'(e.f));
          if (out_ready) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      stalled_prev = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        e.r = vr[sent];
        e.f = vf[sent];
        e.t = 4'(sent);
        sb.push_back(e);
        sent++;
      end
      cyc++;
    end
    chk({nm, "_count"}, 64'(got), 64'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1 chk({nm, "_drain"}, 64'(out_valid), 64'd0);
    end
    va.delete();
    vb.delete();
    vr.delete();
    vf.delete();
  endtask

  task automatic single_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tg, input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    in_tag    = tg;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({nm, "_lat0"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 chk({nm, "_lat2"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 chk({nm, "_lat3"}, 64'(out_valid), 64'd1);
    chk({nm, "_result"}, 64'(result), 64'(er));
    chk({nm, "_tag"}, 64'(out_tag), 64'(tg));
    chk({nm, "_flags"}, 64'(flags()), 64'(ef));
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_operand = '0;
    b_operand = '0;
    in_tag    = '0;

    #3;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_tag", 64'(out_tag), 64'd0);
    chk("reset_flags", 64'(flags()), 64'd0);
    #9 rst = 1'b1;

    single_op("mul3x2", 32'h40400000, 32'h40000000, 4'h5, 32'h40C00000, 4'b0000);

    add_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    add_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    add_op(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    add_op(32'hFF000000, 32'h40000000, 32'hFF800000, 4'b0101);
    add_op(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    add_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    add_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    add_op(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    add_op(32'hFF800000, 32'h7F800000, 32'hFF800000, 4'b0000);
    add_op(32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    add_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
    add_op(32'h3FBFFFFF, 32'h3FAAAAAB, 32'h3FFFFFFF, 4'b0001);
    run_stream("directed", 1'b0);

    add_rand(8);
    run_stream("bp8", 1'b1);

    add_rand(200);
    run_stream("rand", 1'b1);

    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      a_operand = 32'h40400000;
      b_operand = 32'h40000000;
      in_tag    = 4'(8 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_result", 64'(result), 64'd0);
    chk("async_reset_tag", 64'(out_tag), 64'd0);
    chk("async_reset_flags", 64'(flags()), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1 chk("post_reset_idle", 64'(out_valid), 64'd0);
    end
    single_op("one_x_one", 32'h3F800000, 32'h3F800000, 4'hA, 32'h3F800000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
